// File: rtl/ppc60x_pkg.sv
// Shared 60x bus encodings: transfer types, transfer sizes and master FSM states.
// Vectors use big-endian bit numbering (bit 0 = MSB), matching the bus.
package ppc60x_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_AWAIT = 3'd3,
        ST_DWAIT = 3'd4,
        ST_DATA  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam logic [0:4] TT_READ  = 5'b01010;
    localparam logic [0:4] TT_WRITE = 5'b00010;

    localparam logic [0:2] TSIZ_BYTE = 3'b001;
    localparam logic [0:2] TSIZ_HALF = 3'b010;
    localparam logic [0:2] TSIZ_WORD = 3'b100;

    localparam logic [0:1] SIZE_BYTE = 2'b00;
    localparam logic [0:1] SIZE_HALF = 2'b01;

endpackage

// File: rtl/ppc60x_tsiz_enc.sv
// Client SIZE to 60x TSIZ mapping; the illegal code 11 is treated as a word.
module ppc60x_tsiz_enc
    import ppc60x_pkg::*;
(
    input  logic [0:1] size,
    output logic [0:2] tsiz
);

    always_comb begin
        case (size)
            SIZE_BYTE: tsiz = TSIZ_BYTE;
            SIZE_HALF: tsiz = TSIZ_HALF;
            default:   tsiz = TSIZ_WORD;
        endcase
    end

endmodule

// File: rtl/ppc60x_bus_master.sv
// Single-beat PowerPC 60x bus master: arbitration, address tenure and data tenure
// for byte/halfword/word client requests. All bus outputs are registered.
module ppc60x_bus_master
    import ppc60x_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned MAX_RETRY   = 4
) (
    input  logic        CLK,
    input  logic        HRESET_N,
    input  logic        REQ,
    input  logic        WE,
    input  logic [0:31] ADDR,
    input  logic [0:1]  SIZE,
    input  logic [0:31] WDATA,
    output logic        ACK,
    output logic        ERR,
    output logic [0:31] RDATA,
    output logic        BUSY,
    output logic        BR,
    input  logic        BG,
    output logic        TS,
    output logic [0:31] A,
    output logic [0:4]  TT,
    output logic [0:2]  TSIZ,
    output logic        TBST,
    input  logic        AACK,
    input  logic        ARTRY,
    input  logic        DBG,
    input  logic        TA,
    input  logic        TEA,
    output logic [0:31] DL_O,
    output logic        DL_OE,
    input  logic [0:31] DH_I
);

    state_t      state, state_nxt;
    logic [7:0]  retry_cnt, retry_nxt, retry_inc;
    logic [7:0]  tmo_cnt, tmo_nxt, tmo_inc;
    logic        timeout_hit, retry_done;
    logic        err_nxt, rd_load;
    logic        addr_phase, wr_phase;

    logic        we_q;
    logic [0:31] addr_q;
    logic [0:1]  size_q;
    logic [0:31] wdata_q;
    logic [0:2]  tsiz_q;

    ppc60x_tsiz_enc u_tsiz_enc (
        .size (size_q),
        .tsiz (tsiz_q)
    );

    assign TBST = 1'b1;

    // Timeout counter saturates so it can never wrap back below the limit.
    assign tmo_inc     = (tmo_cnt == 8'hFF) ? tmo_cnt : tmo_cnt + 8'd1;
    assign timeout_hit = (tmo_inc >= 8'(TIMEOUT_CYC));
    assign retry_inc   = retry_cnt + 8'd1;
    assign retry_done  = (retry_inc >= 8'(MAX_RETRY));

    always_ff @(posedge CLK or negedge HRESET_N) begin
        if (!HRESET_N) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        tmo_nxt   = tmo_cnt;
        err_nxt   = 1'b0;
        rd_load   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (REQ) begin
                    state_nxt = ST_ARB;
                    retry_nxt = '0;
                end
            end
            ST_ARB: begin
                if (!BG) state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                state_nxt = ST_AWAIT;
                tmo_nxt   = '0;
            end
            ST_AWAIT: begin
                tmo_nxt = tmo_inc;
                // ARTRY outranks AACK when both arrive in the same cycle.
                if (!ARTRY) begin
                    retry_nxt = retry_inc;
                    if (retry_done) begin
                        state_nxt = ST_DONE;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = ST_ARB;
                    end
                end else if (!AACK) begin
                    state_nxt = ST_DWAIT;
                end else if (timeout_hit) begin
                    state_nxt = ST_DONE;
                    err_nxt   = 1'b1;
                end
            end
            ST_DWAIT: begin
                tmo_nxt = tmo_inc;
                if (!DBG) begin
                    state_nxt = ST_DATA;
                end else if (timeout_hit) begin
                    state_nxt = ST_DONE;
                    err_nxt   = 1'b1;
                end
            end
            ST_DATA: begin
                tmo_nxt = tmo_inc;
                if (!TEA) begin
                    state_nxt = ST_DONE;
                    err_nxt   = 1'b1;
                end else if (!TA) begin
                    state_nxt = ST_DONE;
                    rd_load   = !we_q;
                end else if (timeout_hit) begin
                    state_nxt = ST_DONE;
                    err_nxt   = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign addr_phase = (state_nxt == ST_ADDR) || (state_nxt == ST_AWAIT);
    assign wr_phase   = (state_nxt == ST_DATA) && we_q;

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge CLK or negedge HRESET_N) begin
        if (!HRESET_N) begin
            retry_cnt <= '0;
            tmo_cnt   <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            BR        <= 1'b1;
            TS        <= 1'b1;
            A         <= '0;
            TT        <= '0;
            TSIZ      <= '0;
            DL_O      <= '0;
            DL_OE     <= 1'b0;
            ACK       <= 1'b0;
            ERR       <= 1'b0;
            RDATA     <= '0;
            BUSY      <= 1'b0;
        end else begin
            retry_cnt <= retry_nxt;
            tmo_cnt   <= tmo_nxt;
            if (state == ST_IDLE && REQ) begin
                we_q    <= WE;
                addr_q  <= ADDR;
                size_q  <= SIZE;
                wdata_q <= WDATA;
            end
            BR    <= (state_nxt != ST_ARB);
            TS    <= (state_nxt != ST_ADDR);
            A     <= addr_phase ? addr_q : '0;
            TT    <= addr_phase ? (we_q ? TT_WRITE : TT_READ) : '0;
            TSIZ  <= addr_phase ? tsiz_q : '0;
            DL_OE <= wr_phase;
            DL_O  <= wr_phase ? wdata_q : '0;
            ACK   <= (state_nxt == ST_DONE);
            ERR   <= err_nxt;
            BUSY  <= (state_nxt != ST_IDLE);
            if (rd_load) RDATA <= DH_I;
        end
    end

endmodule

// File: tb/tb_ppc60x_bus_master.sv
// Directed bench for ppc60x_bus_master: table of transactions against a reactive
// 60x responder, plus hand-written reset checks.
module tb_ppc60x_bus_master;

    logic        CLK = 1'b0;
    logic        HRESET_N;
    logic        REQ, WE;
    logic [0:31] ADDR, WDATA, RDATA, A, DL_O, DH_I;
    logic [0:1]  SIZE;
    logic        ACK, ERR, BUSY, BR, BG, TS, TBST;
    logic [0:4]  TT;
    logic [0:2]  TSIZ;
    logic        AACK, ARTRY, DBG, TA, TEA, DL_OE;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    ppc60x_bus_master #(.TIMEOUT_CYC(16), .MAX_RETRY(4)) dut (
        .CLK(CLK), .HRESET_N(HRESET_N), .REQ(REQ), .WE(WE), .ADDR(ADDR), .SIZE(SIZE),
        .WDATA(WDATA), .ACK(ACK), .ERR(ERR), .RDATA(RDATA), .BUSY(BUSY), .BR(BR), .BG(BG),
        .TS(TS), .A(A), .TT(TT), .TSIZ(TSIZ), .TBST(TBST), .AACK(AACK), .ARTRY(ARTRY),
        .DBG(DBG), .TA(TA), .TEA(TEA), .DL_O(DL_O), .DL_OE(DL_OE), .DH_I(DH_I)
    );

    typedef struct {
        logic        we;
        logic [0:31] addr;
        logic [0:1]  size;
        logic [0:31] wdata;
        logic [0:31] dh;
        int          bg_delay;
        int          n_artry;
        logic        aack_ok;
        logic        ta;
        logic        tea;
        int          exp_ts;
        logic [0:4]  exp_tt;
        logic [0:2]  exp_tsiz;
        logic        exp_err;
        logic [0:31] exp_rdata;
        int          exp_lat;
    } vec_t;

    typedef struct {
        int          ts_count;
        int          cyc_ts_first;
        int          cyc_ts;
        int          br_low;
        int          cyc_ack;
        logic [0:31] a;
        logic [0:4]  tt;
        logic [0:2]  tsiz;
        logic        busy_ts;
        logic        tbst_ts;
        logic        dl_seen;
        logic [0:31] dl_val;
        logic        ack_seen;
        logic        err;
        logic [0:31] rdata;
        logic        dloe_ack;
        logic        br_ack;
        logic        ts_ack;
        logic        bus_zero_ack;
        logic        ack_after;
        logic        busy_after;
    } obs_t;

    localparam logic [0:4] TTW = 5'b00010;
    localparam logic [0:4] TTR = 5'b01010;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        REQ = 1'b0; BG = 1'b1; AACK = 1'b1; ARTRY = 1'b1;
        DBG = 1'b1; TA = 1'b1; TEA = 1'b1;
    endtask

    // Called just after a negedge; drives one request and plays the bus side until ACK.
    task automatic run_txn(input vec_t v, output obs_t o);
        int bg_wait;
        int artry_left;
        bg_wait    = 0;
        artry_left = v.n_artry;
        o = '{default: '0};
        WE = v.we; ADDR = v.addr; SIZE = v.size; WDATA = v.wdata; DH_I = v.dh;
        TA = v.ta; TEA = v.tea; DBG = 1'b0; REQ = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge CLK);
            REQ = 1'b0;
            if (TS == 1'b0) begin
                o.ts_count++;
                o.cyc_ts = c;
                if (o.ts_count == 1) begin
                    o.cyc_ts_first = c;
                    o.a = A; o.tt = TT; o.tsiz = TSIZ; o.busy_ts = BUSY; o.tbst_ts = TBST;
                end
            end
            if (BR == 1'b0 && o.ts_count == 0) o.br_low++;
            if (DL_OE) begin
                o.dl_seen = 1'b1;
                o.dl_val  = DL_O;
            end
            if (ACK) begin
                o.ack_seen = 1'b1; o.cyc_ack = c; o.err = ERR; o.rdata = RDATA;
                o.dloe_ack = DL_OE; o.br_ack = BR; o.ts_ack = TS;
                o.bus_zero_ack = (A == '0) && (TT == '0) && (TSIZ == '0);
                @(negedge CLK);
                o.ack_after  = ACK;
                o.busy_after = BUSY;
                break;
            end
            BG = 1'b1;
            if (BR == 1'b0) begin
                if (bg_wait < v.bg_delay) bg_wait++;
                else BG = 1'b0;
            end
            ARTRY = 1'b1;
            AACK  = 1'b1;
            if (TS == 1'b1 && TT != 5'b0) begin
                if (artry_left > 0) begin
                    artry_left--;
                    ARTRY = 1'b0;
                    AACK  = 1'b0;
                end else if (v.aack_ok) begin
                    AACK = 1'b0;
                end
            end
        end
        idle_inputs();
    endtask

    task automatic check_vec(input int i, input vec_t v, input obs_t o);
        chk($sformatf("v%0d ack_seen", i), 32'(o.ack_seen), 32'd1);
        chk($sformatf("v%0d ts_count", i), o.ts_count, v.exp_ts);
        chk($sformatf("v%0d first_ts_cycle", i), o.cyc_ts_first, 2 + v.bg_delay);
        chk($sformatf("v%0d br_low_cycles", i), o.br_low, v.bg_delay + 1);
        chk($sformatf("v%0d A", i), o.a, v.addr);
        chk($sformatf("v%0d TT", i), 32'(o.tt), 32'(v.exp_tt));
        chk($sformatf("v%0d TSIZ", i), 32'(o.tsiz), 32'(v.exp_tsiz));
        chk($sformatf("v%0d busy_tbst_at_ts", i), {30'd0, o.busy_ts, o.tbst_ts}, 32'd3);
        chk($sformatf("v%0d dl_seen", i), 32'(o.dl_seen), 32'(v.we));
        chk($sformatf("v%0d DL_O", i), o.dl_val, v.we ? v.wdata : 32'h0);
        chk($sformatf("v%0d ERR", i), 32'(o.err), 32'(v.exp_err));
        chk($sformatf("v%0d RDATA", i), o.rdata, v.exp_rdata);
        chk($sformatf("v%0d ack_latency", i), o.cyc_ack - o.cyc_ts, v.exp_lat);
        chk($sformatf("v%0d released_at_ack", i),
            {28'd0, o.dloe_ack, o.br_ack, o.ts_ack, o.bus_zero_ack}, 32'b0111);
        chk($sformatf("v%0d after_ack_ack_busy", i), {30'd0, o.ack_after, o.busy_after}, 32'd0);
    endtask

    initial begin
        obs_t o;
        int   seen_ack;
        int   found;

        //          we    addr          size   wdata         dh            bgd art aack ta    tea   ts tt   tsiz    err   rdata         lat
        vecs[0] = '{1'b1, 32'h0001_2340, 2'b10, 32'hDEAD_BEEF, 32'h0,        0, 0, 1'b1, 1'b0, 1'b1, 1, TTW, 3'b100, 1'b0, 32'h0,        4};
        vecs[1] = '{1'b0, 32'h0000_0007, 2'b00, 32'h0,        32'hAB00_0000, 0, 0, 1'b1, 1'b0, 1'b1, 1, TTR, 3'b001, 1'b0, 32'hAB00_0000, 4};
        vecs[2] = '{1'b1, 32'h0000_1002, 2'b01, 32'h1234_5678, 32'h0,        5, 0, 1'b1, 1'b0, 1'b1, 1, TTW, 3'b010, 1'b0, 32'hAB00_0000, 4};
        vecs[3] = '{1'b0, 32'hFFFF_FFFC, 2'b11, 32'h0,        32'h0F0F_1234, 0, 0, 1'b1, 1'b0, 1'b0, 1, TTR, 3'b100, 1'b1, 32'hAB00_0000, 4};
        vecs[4] = '{1'b0, 32'h0000_0100, 2'b10, 32'h0,        32'h1111_1111, 0, 4, 1'b1, 1'b0, 1'b1, 4, TTR, 3'b100, 1'b1, 32'hAB00_0000, 2};
        vecs[5] = '{1'b1, 32'h8000_0000, 2'b10, 32'hCAFE_F00D, 32'h0,        1, 2, 1'b1, 1'b0, 1'b1, 3, TTW, 3'b100, 1'b0, 32'hAB00_0000, 4};
        vecs[6] = '{1'b1, 32'h0000_0040, 2'b10, 32'h55AA_55AA, 32'h0,        0, 0, 1'b1, 1'b1, 1'b1, 1, TTW, 3'b100, 1'b1, 32'hAB00_0000, 17};
        vecs[7] = '{1'b0, 32'h0000_0080, 2'b10, 32'h0,        32'h2222_2222, 0, 0, 1'b0, 1'b0, 1'b1, 1, TTR, 3'b100, 1'b1, 32'hAB00_0000, 17};
        vecs[8] = '{1'b1, 32'h0000_0003, 2'b00, 32'h0000_00AA, 32'h0,        0, 0, 1'b1, 1'b0, 1'b1, 1, TTW, 3'b001, 1'b0, 32'hAB00_0000, 4};
        vecs[9] = '{1'b0, 32'h0000_0102, 2'b01, 32'h0,        32'h0000_5A5A, 2, 0, 1'b1, 1'b0, 1'b1, 1, TTR, 3'b010, 1'b0, 32'h0000_5A5A, 4};

        HRESET_N = 1'b0;
        idle_inputs();
        WE = 1'b0; ADDR = '0; SIZE = '0; WDATA = '0; DH_I = '0;
        @(negedge CLK);
        @(negedge CLK);
        chk("reset strobes BR/TS/TBST", {29'd0, BR, TS, TBST}, 32'b111);
        chk("reset A", A, 32'h0);
        chk("reset TT/TSIZ", {24'd0, TT, TSIZ}, 32'h0);
        chk("reset DL_O", DL_O, 32'h0);
        chk("reset DL_OE/ACK/ERR/BUSY", {28'd0, DL_OE, ACK, ERR, BUSY}, 32'h0);
        chk("reset RDATA", RDATA, 32'h0);
        HRESET_N = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i], o);
            check_vec(i, vecs[i], o);
            @(negedge CLK);
        end

        // Reset asserted while a write is in its data tenure.
        WE = 1'b1; ADDR = 32'h0000_0200; SIZE = 2'b10; WDATA = 32'h0BAD_CAFE;
        BG = 1'b0; AACK = 1'b0; DBG = 1'b0; TA = 1'b1; TEA = 1'b1; REQ = 1'b1;
        found = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            REQ = 1'b0;
            if (DL_OE) begin
                found = 1;
                break;
            end
        end
        chk("reset-in-data reached DATA", found, 1);
        chk("reset-in-data DL_O", DL_O, 32'h0BAD_CAFE);
        HRESET_N = 1'b0;
        #1;
        chk("async reset DL_OE/BR/TS/BUSY", {28'd0, DL_OE, BR, TS, BUSY}, 32'b0110);
        seen_ack = 0;
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            if (ACK) seen_ack++;
        end
        HRESET_N = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (ACK) seen_ack++;
        end
        chk("no ACK after reset abort", seen_ack, 0);

        run_txn(vecs[0], o);
        check_vec(10, vecs[0], o);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
